// File: rtl/fp_cvt_unit.sv
// fp_cvt_unit: int32 <-> IEEE-754 single conversion using a one-bit-per-cycle shifter.
module fp_cvt_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        invalid
);
  localparam logic [1:0] IDLE = 2'd0, NORM = 2'd1, PACK = 2'd2;
  logic [1:0] state;
  logic dir_r, sign, byp, inv;
  logic [31:0] mag, abs_op;
  logic [7:0] exp, e_op;
  logic [4:0] cnt;
  logic f_zero, f_min, f_ovf;
  assign abs_op = operand[31] ? -operand : operand;
  assign e_op = operand[30:23];
  assign f_zero = e_op < 8'd127;
  assign f_min = operand == 32'hCF00_0000;
  assign f_ovf = e_op >= 8'd158;
  assign busy = state != IDLE;
  // byp marks special cases whose final result is parked in mag at load time
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      dir_r   <= 1'b0;
      sign    <= 1'b0;
      byp     <= 1'b0;
      inv     <= 1'b0;
      mag     <= '0;
      exp     <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      result  <= '0;
      invalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dir_r <= dir;
            sign  <= operand[31];
            exp   <= 8'd158;
            cnt   <= 5'(8'd158 - e_op);
            if (!dir) begin
              mag   <= abs_op;
              byp   <= abs_op == '0;
              inv   <= 1'b0;
              state <= abs_op == '0 ? PACK : NORM;
            end else if (f_zero | f_min | f_ovf) begin
              mag   <= f_zero ? 32'h0 : f_min ? 32'h8000_0000 : 32'h7FFF_FFFF;
              byp   <= 1'b1;
              inv   <= f_ovf & !f_min;
              state <= PACK;
            end else begin
              mag   <= {1'b1, operand[22:0], 8'b0};
              byp   <= 1'b0;
              inv   <= 1'b0;
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (dir_r ? cnt == '0 : mag[31]) state <= PACK;
          else begin
            mag <= dir_r ? mag >> 1 : mag << 1;
            exp <= exp - 8'd1;
            cnt <= cnt - 5'd1;
          end
        end
        PACK: begin
          result  <= byp ? mag : dir_r ? (sign ? -mag : mag) : {sign, exp, mag[30:8]};
          invalid <= inv;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fp_cvt_unit.sv
// tb_fp_cvt_unit: directed and randomized checks of fp_cvt_unit against a numeric model.
module tb_fp_cvt_unit;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, dir = 1'b0;
  logic [31:0] operand = '0;
  logic busy, done, invalid;
  logic [31:0] result;
  int n_tests = 0, n_fail = 0;

  fp_cvt_unit dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .operand(operand),
    .busy(busy), .done(done), .result(result), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic void ref_i2f(input logic [31:0] op, output logic [31:0] r, output int lat);
    logic [31:0] m;
    logic [31:0] norm;
    int p;
    m = op[31] ? ~op + 32'd1 : op;
    if (m == 0) begin
      r = 0;
      lat = 1;
      return;
    end
    p = 31;
    while (!m[p]) p--;
    norm = m << (31 - p);
    r = {op[31], 8'(127 + p), norm[30:8]};
    lat = 31 - p + 2;
  endfunction

  function automatic void ref_f2i(input logic [31:0] op, output logic [31:0] r, output logic iv, output int lat);
    int e;
    longint v;
    e = int'(op[30:23]);
    iv = 1'b0;
    lat = 1;
    if (e < 127) r = 0;
    else if (op == 32'hCF00_0000) r = 32'h8000_0000;
    else if (e >= 158) begin
      r = 32'h7FFF_FFFF;
      iv = 1'b1;
    end else begin
      v = longint'({1'b1, op[22:0]});
      v = e >= 150 ? v << (e - 150) : v >> (150 - e);
      r = op[31] ? 32'(-v) : 32'(v);
      lat = 158 - e + 2;
    end
  endfunction

  // called just after a rising edge; returns just after the edge that raised done
  task automatic conv(input logic d, input logic [31:0] op, input bit poke,
                      output logic [31:0] r, output logic iv, output int lat);
    start = 1'b1;
    dir = d;
    operand = op;
    @(posedge clk);
    #1;
    start = 1'b0;
    operand = $urandom;
    dir = ~d;
    lat = 0;
    r = 'x;
    iv = 1'bx;
    forever begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (busy && done) chk("overlap", 32'd1, 32'd0);
      if (done) begin
        r = result;
        iv = invalid;
        break;
      end
      chk("busy", 32'(busy), 32'd1);
      if (lat >= 40) begin
        chk("timeout", 32'(lat), 32'd0);
        break;
      end
      if (poke && lat == 2) begin
        start = 1'b1;
        dir = $urandom_range(1);
        operand = $urandom;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic d, input logic [31:0] op, input bit poke,
                           input logic [31:0] want_r, input logic want_iv, input int want_lat);
    logic [31:0] r;
    logic iv;
    int lat;
    conv(d, op, poke, r, iv, lat);
    chk({tag, ".res"}, r, want_r);
    chk({tag, ".inv"}, 32'(iv), 32'(want_iv));
    chk({tag, ".lat"}, 32'(lat), 32'(want_lat));
  endtask

  typedef struct {logic d; logic [31:0] op; logic [31:0] r; logic iv; int lat;} vec_t;
  vec_t vecs[14] = '{
    '{1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33},
    '{1'b0, 32'h0000_0005, 32'h40A0_0000, 1'b0, 31},
    '{1'b0, 32'hFFFF_FFFA, 32'hC0C0_0000, 1'b0, 31},
    '{1'b0, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b0, 3},
    '{1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 2},
    '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1},
    '{1'b1, 32'h40A0_0000, 32'h0000_0005, 1'b0, 31},
    '{1'b1, 32'hC030_0000, 32'hFFFF_FFFE, 1'b0, 32},
    '{1'b1, 32'h3F00_0000, 32'h0000_0000, 1'b0, 1},
    '{1'b1, 32'hCF00_0000, 32'h8000_0000, 1'b0, 1},
    '{1'b1, 32'h5015_02F9, 32'h7FFF_FFFF, 1'b1, 1},
    '{1'b1, 32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1},
    '{1'b1, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1},
    '{1'b1, 32'hD000_0000, 32'h7FFF_FFFF, 1'b1, 1}
  };

  initial begin
    logic [31:0] op, wr;
    logic wi;
    int wl, seen;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.res", result, 32'd0);
    chk("rst.inv", 32'(invalid), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    foreach (vecs[i])
      run_check($sformatf("dir%0d_%h", vecs[i].d, vecs[i].op), vecs[i].d, vecs[i].op,
                vecs[i].lat > 4, vecs[i].r, vecs[i].iv, vecs[i].lat);
    // reset in the middle of a long int->float normalisation
    start = 1'b1;
    dir = 1'b0;
    operand = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.res", result, 32'd0);
    chk("abort.inv", 32'(invalid), 32'd0);
    #5;
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abort.quiet", 32'(seen), 32'd0);
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) begin
        op = $urandom >> $urandom_range(31);
        if ($urandom_range(1)) op = -op;
        ref_i2f(op, wr, wl);
        run_check($sformatf("rnd_i2f_%h", op), 1'b0, op, i % 4 == 0 && wl > 4, wr, 1'b0, wl);
      end else begin
        op = {1'($urandom), 8'($urandom_range(120, 162)), 23'($urandom)};
        ref_f2i(op, wr, wi, wl);
        run_check($sformatf("rnd_f2i_%h", op), 1'b1, op, i % 4 == 1 && wl > 4, wr, wi, wl);
      end
    end
    @(posedge clk);
    #1;
    chk("done.pulse", 32'(done), 32'd0);
    chk("hold.busy", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_cvt_unit.md
# fp_cvt_unit

Multi-cycle conversion unit for the floating-point coprocessor: it moves values between the integer datapath and IEEE-754 single-precision format. It implements cvt.s.w (int32 → float, packing sign/exponent/mantissa) and cvt.w.s (float → int32, unpacking and truncating). It sits beside the FP add/sub ALU, between the integer register file and the FP register file. Normalisation and denormalisation use an iterative one-bit-per-cycle shifter under a start/done handshake.

## Interface
Parameters:
- none (width fixed at 32, exponent bias fixed at 127)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs immediately
- start  in  1  request; sampled only in IDLE
- dir  in  1  0 = int32 → float (cvt.s.w); 1 = float → int32 (cvt.w.s); sampled with start
- operand  in  32  source value; sampled with start
- busy  out  1  high while a conversion is in flight
- done  out  1  one-cycle pulse; result/invalid valid from this cycle onward
- result  out  32  converted value; holds until the next done
- invalid  out  1  float → int source out of range/NaN/Inf; updated with done

## Operation
- States: IDLE, NORM, PACK.
- IDLE:
  - start=1 latches dir/operand into working registers.
  - Goes to NORM, or directly to PACK for special cases.
  - busy=1 from the next cycle.
- int → float load:
  - sign = operand[31]; mag = |operand| (32-bit unsigned; 0x80000000 → mag 2^31); exp = 158.
  - mag == 0 → PACK with result 0x00000000.
- int → float NORM:
  - If mag[31] == 1 → PACK.
  - Else mag <<= 1, exp -= 1.
- int → float PACK:
  - result = {sign, exp[7:0], mag[30:8]}.
  - Truncation toward zero; no rounding. invalid = 0.
- float → int load:
  - s = op[31]; e = op[30:23]; mag = {1, op[22:0], 8'b0}.
  - e < 127 (includes ±0, denormals) → PACK, result 0.
  - op == 0xCF000000 → PACK, result 0x80000000, invalid = 0.
  - Any other e ≥ 158 (overflow, Inf, NaN) → PACK, result 0x7FFFFFFF, invalid = 1.
  - Else cnt = 158 − e (1..31, 5-bit) → NORM.
- float → int NORM:
  - If cnt == 0 → PACK.
  - Else mag >>= 1 (logical), cnt -= 1.
- float → int PACK:
  - result = s ? −mag : mag (two's complement, 32-bit). invalid = 0.
- PACK → IDLE unconditionally.
  - On that edge, result, invalid and done=1 are registered and busy drops.
- start while busy is ignored.
  - No queueing.
  - No change to the in-flight operation.

## Timing
- Reset values: busy=0, done=0, result=0x00000000, invalid=0, state=IDLE.
- Reset asserted mid-operation aborts immediately; no done is produced.
- Let E0 be the edge sampling start, and N the shift count:
  - int → float: N = leading zeros of mag.
  - float → int: N = cnt.
- Normal path:
  - NORM shifts on E1..EN.
  - E(N+1) moves to PACK.
  - done is high in the cycle after E(N+2).
- Latency range:
  - Minimum normal path (N=0): done after E2.
  - Maximum (int 1 → float, N=31): done after E33.
- Special cases (zero, out-of-range, e<127): PACK at E0; done after E1.
- busy is high from after E0 through the cycle before done; busy and done are never both 1.
- done lasts exactly one cycle.
- start asserted in the done cycle is accepted, since the FSM is already in IDLE.
- result/invalid are stable between done pulses.

## Test plan
- Reset: assert reset mid-NORM (e.g. operand 1, dir 0, 10 cycles in) → busy, done, result, invalid read 0 immediately; no done pulse after release.
- int → float:
  - 1 → 0x3F800000, done after E33.
  - 5 → 0x40A00000, done after E31.
  - −6 → 0xC0C00000.
  - 0x7FFFFFFF → 0x4EFFFFFF (truncated).
  - 0x80000000 → 0xCF000000, done after E2.
  - 0 → 0x00000000, done after E1.
- float → int:
  - 0x40A00000 (5.0) → 5, done after E31.
  - 0xC0300000 (−2.75) → 0xFFFFFFFE.
  - 0x3F000000 (0.5) → 0, done after E1.
  - 0xCF000000 → 0x80000000, invalid=0.
- Invalid: 0x501502F9 (1e10), 0x7F800000 (+Inf), 0x7FC00000 (NaN), 0xD0000000 → result 0x7FFFFFFF, invalid=1, done after E1.
- Handshake:
  - Pulse start with a different operand while busy → ignored; first result unchanged.
  - Assert start in the done cycle → second conversion accepted.
  - Back-to-back results correct; busy/done never overlap.
